// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline front end: fetch FSM states,
// the IF/ID record and PC arithmetic constants.
package mips_pkg;

    typedef enum logic [1:0] {
        REPOSO  = 2'd0,
        PEDIR   = 2'd1,
        RETENER = 2'd2
    } estado_t;

    // sll $0,$0,0 -- the canonical bubble
    localparam logic [31:0] NOP_WORD     = 32'h0000_0000;
    localparam logic [31:0] PC_INCREMENT = 32'd4;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc_plus4;
        logic        valida;
    } if_id_t;

    // Word-align a branch/jump target; the two low bits are meaningless
    function automatic logic [31:0] alinear(input logic [31:0] a);
        return a & ~32'd3;
    endfunction

endpackage

// File: rtl/etapa_busqueda_registro_if_id.sv
// IF/ID pipeline register: flush beats stall, stall holds contents.
module registro_if_id
    import mips_pkg::*;
#(
    parameter logic [31:0] NOP = NOP_WORD
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   flush,
    input  logic   enable,
    input  if_id_t d,
    output if_id_t q
);

    // Reset and flush both inject a bubble; otherwise load only when enabled
    always_ff @(posedge clk) begin
        if (reset || flush)
            q <= '{instr: NOP, pc_plus4: 32'h0, valida: 1'b0};
        else if (enable)
            q <= d;
    end

endmodule

// File: rtl/etapa_busqueda.sv
// Instruction-fetch stage: owns the PC, talks req/ready to instruction
// memory, parks a word fetched under a decode stall, and feeds IF/ID.
module etapa_busqueda
    import mips_pkg::*;
#(
    parameter logic [31:0] PC_RESET = 32'h0000_0000,
    parameter logic [31:0] NOP      = NOP_WORD
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        detener,
    input  logic        cambiar_pc,
    input  logic [31:0] nueva_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_dato,
    output logic [31:0] instruccion,
    output logic [31:0] pc_plus4_out,
    output logic        valida_id
);

    estado_t     estado, estado_sig;
    logic [31:0] pc, pc_sig, pc_mas4;
    if_id_t      buffer, if_id_d, if_id_q;
    logic        acepta, carga_buffer;

    // Memory interface depends only on state and PC
    assign imem_req  = (estado == PEDIR);
    assign imem_addr = pc;
    assign pc_mas4   = pc + PC_INCREMENT;
    assign acepta    = imem_req && imem_ready;

    // State and PC registers
    always_ff @(posedge clk) begin
        if (reset) begin
            estado <= REPOSO;
            pc     <= PC_RESET;
        end else begin
            estado <= estado_sig;
            pc     <= pc_sig;
        end
    end

    // Holding buffer for a word that arrived while decode was stalled
    always_ff @(posedge clk) begin
        if (reset || cambiar_pc)
            buffer <= '{instr: NOP, pc_plus4: 32'h0, valida: 1'b0};
        else if (carga_buffer)
            buffer <= '{instr: imem_dato, pc_plus4: pc_mas4, valida: 1'b1};
    end

    // Next state, next PC and IF/ID input; redirect overrides everything
    always_comb begin
        estado_sig   = estado;
        pc_sig       = pc;
        carga_buffer = 1'b0;
        if_id_d      = '{instr: NOP, pc_plus4: 32'h0, valida: 1'b0};
        case (estado)
            REPOSO: estado_sig = PEDIR;
            PEDIR: begin
                if (acepta) begin
                    pc_sig = pc_mas4;
                    if (detener) begin
                        carga_buffer = 1'b1;
                        estado_sig   = RETENER;
                    end else begin
                        if_id_d = '{instr: imem_dato, pc_plus4: pc_mas4, valida: 1'b1};
                    end
                end
            end
            RETENER: begin
                if_id_d = buffer;
                if (!detener)
                    estado_sig = PEDIR;
            end
            default: estado_sig = REPOSO;
        endcase
        if (cambiar_pc) begin
            estado_sig   = PEDIR;
            pc_sig       = alinear(nueva_pc);
            carga_buffer = 1'b0;
        end
    end

    registro_if_id #(.NOP(NOP)) u_if_id (
        .clk    (clk),
        .reset  (reset),
        .flush  (cambiar_pc),
        .enable (!detener),
        .d      (if_id_d),
        .q      (if_id_q)
    );

    assign instruccion  = if_id_q.instr;
    assign pc_plus4_out = if_id_q.pc_plus4;
    assign valida_id    = if_id_q.valida;

endmodule

// File: tb/tb_etapa_busqueda.sv
// Bench for the fetch stage: memory model returns addr|A000_0000, a
// scoreboard holds every word expected to reach IF/ID in order.
module tb_etapa_busqueda;

    localparam logic [31:0] PC_RST = 32'h0000_0100;
    localparam logic [31:0] BUBBLE = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset, detener, cambiar_pc, imem_ready;
    logic [31:0] nueva_pc, imem_dato;
    logic        imem_req, valida_id;
    logic [31:0] imem_addr, instruccion, pc_plus4_out;

    exp_t sb[$];
    exp_t e;
    int   errors = 0;
    int   checks = 0;
    logic upd = 1'b0;

    always #5 clk = ~clk;

    assign imem_dato = imem_addr | 32'hA000_0000;

    etapa_busqueda #(.PC_RESET(PC_RST), .NOP(BUBBLE)) dut (
        .clk          (clk),
        .reset        (reset),
        .detener      (detener),
        .cambiar_pc   (cambiar_pc),
        .nueva_pc     (nueva_pc),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ready   (imem_ready),
        .imem_dato    (imem_dato),
        .instruccion  (instruccion),
        .pc_plus4_out (pc_plus4_out),
        .valida_id    (valida_id)
    );

    // IF/ID may only take new content on an edge without reset or stall
    always @(posedge clk) upd <= !reset && !detener;

    // Scoreboard: every valid word newly loaded into IF/ID must match
    always @(negedge clk) begin
        if (upd && valida_id) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got instr=%h pc4=%h, required no valid word", instruccion, pc_plus4_out);
            end else begin
                e = sb.pop_front();
                if (instruccion !== e.instr || pc_plus4_out !== e.pc4) begin
                    errors++;
                    $display("FAIL sb_word: got instr=%h pc4=%h, required instr=%h pc4=%h",
                             instruccion, pc_plus4_out, e.instr, e.pc4);
                end
            end
        end
    end

    task automatic push_word(input logic [31:0] addr);
        sb.push_back('{instr: addr | 32'hA000_0000, pc4: addr + 32'd4});
    endtask

    task automatic test_reset();
        reset = 1'b1; detener = 1'b0; cambiar_pc = 1'b0; nueva_pc = '0; imem_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (imem_req !== 1'b0 || imem_addr !== PC_RST) begin
            errors++;
            $display("FAIL reset_mem: got req=%b addr=%h, required req=0 addr=%h", imem_req, imem_addr, PC_RST);
        end
        checks++;
        if (instruccion !== BUBBLE || pc_plus4_out !== 32'h0 || valida_id !== 1'b0) begin
            errors++;
            $display("FAIL reset_ifid: got instr=%h pc4=%h v=%b, required 0/0/0", instruccion, pc_plus4_out, valida_id);
        end
        // ready while no request is outstanding must be ignored
        reset = 1'b0; imem_ready = 1'b1;
    endtask

    task automatic test_zero_wait();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== PC_RST + 32'(4 * i)) begin
                errors++;
                $display("FAIL zw_addr%0d: got req=%b addr=%h, required req=1 addr=%h", i, imem_req, imem_addr, PC_RST + 32'(4 * i));
            end
            push_word(PC_RST + 32'(4 * i));
        end
        @(negedge clk);
    endtask

    task automatic test_stall();
        checks++;
        if (imem_addr !== 32'h108) begin
            errors++;
            $display("FAIL stall_addr: got %h, required 00000108", imem_addr);
        end
        push_word(32'h108);
        detener = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (imem_req !== 1'b0 || instruccion !== 32'hA000_0104 || pc_plus4_out !== 32'h108 || valida_id !== 1'b1) begin
                errors++;
                $display("FAIL stall_hold%0d: got req=%b instr=%h pc4=%h v=%b, required 0/A0000104/00000108/1",
                         i, imem_req, instruccion, pc_plus4_out, valida_id);
            end
        end
        detener = 1'b0;
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h10C) begin
            errors++;
            $display("FAIL stall_resume: got req=%b addr=%h, required 1/0000010C", imem_req, imem_addr);
        end
        push_word(32'h10C);
        @(negedge clk);
    endtask

    task automatic test_redirect();
        checks++;
        if (imem_addr !== 32'h110) begin
            errors++;
            $display("FAIL redir_pre: got %h, required 00000110", imem_addr);
        end
        imem_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h110 || valida_id !== 1'b0) begin
            errors++;
            $display("FAIL redir_wait: got req=%b addr=%h v=%b, required 1/00000110/0", imem_req, imem_addr, valida_id);
        end
        cambiar_pc = 1'b1; nueva_pc = 32'h0000_2003; imem_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h2000 || instruccion !== BUBBLE || valida_id !== 1'b0) begin
            errors++;
            $display("FAIL redir_target: got req=%b addr=%h instr=%h v=%b, required 1/00002000/0/0",
                     imem_req, imem_addr, instruccion, valida_id);
        end
        cambiar_pc = 1'b0;
        push_word(32'h2000);
        @(negedge clk);
    endtask

    task automatic test_redirect_stall();
        checks++;
        if (imem_addr !== 32'h2004) begin
            errors++;
            $display("FAIL rs_pre: got %h, required 00002004", imem_addr);
        end
        detener = 1'b1;
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b0 || instruccion !== 32'hA000_2000) begin
            errors++;
            $display("FAIL rs_retener: got req=%b instr=%h, required 0/A0002000", imem_req, instruccion);
        end
        cambiar_pc = 1'b1; nueva_pc = 32'h0000_3000;
        @(negedge clk);
        checks++;
        if (instruccion !== BUBBLE || valida_id !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h3000) begin
            errors++;
            $display("FAIL rs_flush: got instr=%h v=%b req=%b addr=%h, required 0/0/1/00003000",
                     instruccion, valida_id, imem_req, imem_addr);
        end
        cambiar_pc = 1'b0; detener = 1'b0;
        push_word(32'h3000);
        @(negedge clk);
        checks++;
        if (imem_addr !== 32'h3004) begin
            errors++;
            $display("FAIL rs_next: got %h, required 00003004", imem_addr);
        end
        push_word(32'h3004);
        @(negedge clk);
    endtask

    task automatic test_wrap();
        cambiar_pc = 1'b1; nueva_pc = 32'hFFFF_FFFC;
        @(negedge clk);
        checks++;
        if (imem_addr !== 32'hFFFF_FFFC) begin
            errors++;
            $display("FAIL wrap_target: got %h, required FFFFFFFC", imem_addr);
        end
        cambiar_pc = 1'b0;
        push_word(32'hFFFF_FFFC);
        @(negedge clk);
        checks++;
        if (imem_addr !== 32'h0 || pc_plus4_out !== 32'h0 || valida_id !== 1'b1) begin
            errors++;
            $display("FAIL wrap_pc: got addr=%h pc4=%h v=%b, required 00000000/00000000/1", imem_addr, pc_plus4_out, valida_id);
        end
        push_word(32'h0);
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        reset = 1'b1; cambiar_pc = 1'b1; nueva_pc = 32'h0000_5000; imem_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b0 || imem_addr !== PC_RST || instruccion !== BUBBLE || pc_plus4_out !== 32'h0 || valida_id !== 1'b0) begin
            errors++;
            $display("FAIL rmid_state: got req=%b addr=%h instr=%h pc4=%h v=%b, required 0/%h/0/0/0",
                     imem_req, imem_addr, instruccion, pc_plus4_out, valida_id, PC_RST);
        end
        reset = 1'b0; cambiar_pc = 1'b0;
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== PC_RST) begin
            errors++;
            $display("FAIL rmid_refetch: got req=%b addr=%h, required 1/%h", imem_req, imem_addr, PC_RST);
        end
        push_word(PC_RST);
        @(negedge clk);
        imem_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d pending words, required 0", sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_stall();
        test_redirect();
        test_redirect_stall();
        test_wrap();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
